// File: rtl/waveform_shaper.sv
// waveform_shaper
//
// Turns the phase word coming out of the oscillator's phase accumulator into
// a signed audio sample for the voice mixer. It offers four waveforms: saw,
// pulse, triangle, and a sine built from a quarter-wave lookup table. The
// block is a fully pipelined, fixed-latency stage. It accepts one sample per
// enable, and enables may arrive back to back.
//
// Parameters
//   WORD_BITS     phase word width (must match the accumulator)
//   OUT_BITS      signed output sample width (OUT_BITS <= WORD_BITS-1)
//   LUT_BITS      quarter-wave table address width (LUT_BITS <= WORD_BITS-2)
//
// Ports
//   clk_i          system clock, rising edge
//   n_rst_i        synchronous active-low reset
//   enable_i       sample strobe; inputs below are captured when high
//   phase_i        unsigned phase, full scale = one period
//   wave_sel_i     0 saw, 1 pulse, 2 triangle, 3 sine
//   pulse_width_i  pulse duty threshold in phase units
//   sample_o       signed two's-complement sample
//   valid_o        one-cycle strobe, sample_o updated this cycle
//
// Pipeline
//   S1  computes the saw/pulse/triangle result, the LUT address and the
//       quadrant flags
//   S2  registered ROM read; the S1 results travel alongside
//   S3  sine negation, final mux, output register
// An enable sampled at edge n therefore produces valid_o after edge n+2,
// which is three cycles of latency.

module waveform_shaper #(
    parameter int WORD_BITS = 32,
    parameter int OUT_BITS  = 16,
    parameter int LUT_BITS  = 10
) (
    input  logic                 clk_i,
    input  logic                 n_rst_i,
    input  logic                 enable_i,
    input  logic [WORD_BITS-1:0] phase_i,
    input  logic [1:0]           wave_sel_i,
    input  logic [WORD_BITS-1:0] pulse_width_i,
    output logic [OUT_BITS-1:0]  sample_o,
    output logic                 valid_o
);

    localparam int LUT_DEPTH  = 1 << LUT_BITS;
    localparam int ENTRY_BITS = OUT_BITS - 1;

    // +A, -A and M (the sign bit, used to map unsigned ramps onto signed values)
    localparam logic [OUT_BITS-1:0] AMP     = {1'b0, {(OUT_BITS-1){1'b1}}};
    localparam logic [OUT_BITS-1:0] NEG_AMP = {1'b1, {(OUT_BITS-2){1'b0}}, 1'b1};
    localparam logic [OUT_BITS-1:0] MSB     = {1'b1, {(OUT_BITS-1){1'b0}}};

    // Table entry k = round(A * sin(pi/2 * (k + 0.5) / N)).
    // Each entry samples the middle of its address bin. Because of that
    // half-bin offset, the mirrored quadrants join without a repeated
    // sample. The sine is evaluated with a Taylor series so that elaboration
    // does not depend on a math library. Over [0, pi/2] the truncation error
    // of this series is far below one LSB.
    function automatic logic [ENTRY_BITS-1:0] sine_entry(input int k);
        real x;
        real term;
        real sum;
        x    = 1.5707963267948966 * (real'(k) + 0.5) / real'(LUT_DEPTH);
        term = x;
        sum  = x;
        for (int n = 1; n < 10; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return ENTRY_BITS'($rtoi(real'(AMP) * sum + 0.5));
    endfunction

    logic [ENTRY_BITS-1:0] rom [LUT_DEPTH];

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
        localparam logic [ENTRY_BITS-1:0] ENTRY = sine_entry(k);
        assign rom[k] = ENTRY;
    end

    // Pipeline registers
    logic                  s1_valid_q, s1_valid_d;
    logic [LUT_BITS-1:0]   s1_addr_q,  s1_addr_d;
    logic                  s1_neg_q,   s1_neg_d;
    logic                  s1_sine_q,  s1_sine_d;
    logic [OUT_BITS-1:0]   s1_wave_q,  s1_wave_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [ENTRY_BITS-1:0] s2_rom_q,   s2_rom_d;
    logic                  s2_neg_q,   s2_neg_d;
    logic                  s2_sine_q,  s2_sine_d;
    logic [OUT_BITS-1:0]   s2_wave_q,  s2_wave_d;

    logic                  valid_q,    valid_d;
    logic [OUT_BITS-1:0]   sample_q,   sample_d;

    // Stage 1 intermediates
    logic [OUT_BITS-1:0]   saw_val;
    logic [OUT_BITS-1:0]   pulse_val;
    logic [OUT_BITS:0]     tri_phase;
    logic [OUT_BITS-1:0]   tri_ramp;
    logic [OUT_BITS-1:0]   tri_val;
    logic [1:0]            quadrant;
    logic [LUT_BITS-1:0]   lut_idx;
    logic [OUT_BITS-1:0]   sine_val;

    // S1: every waveform except sine is finished here. Sine only needs its
    // table address and a negate flag.
    always_comb begin
        saw_val   = phase_i[WORD_BITS-1 -: OUT_BITS] ^ MSB;
        pulse_val = (phase_i < pulse_width_i) ? AMP : NEG_AMP;

        // Triangle: one extra phase bit picks the falling half, where the
        // ramp is folded back down.
        tri_phase = phase_i[WORD_BITS-1 -: OUT_BITS+1];
        tri_ramp  = tri_phase[OUT_BITS] ? ~tri_phase[OUT_BITS-1:0]
                                        : tri_phase[OUT_BITS-1:0];
        tri_val   = tri_ramp ^ MSB;

        // Odd quadrants read the table backwards. The second half of the
        // period is the negated first half.
        quadrant  = phase_i[WORD_BITS-1 -: 2];
        lut_idx   = phase_i[WORD_BITS-3 -: LUT_BITS];
        s1_addr_d = quadrant[0] ? ~lut_idx : lut_idx;
        s1_neg_d  = quadrant[1];
        s1_sine_d = (wave_sel_i == 2'd3);

        case (wave_sel_i)
            2'd1:    s1_wave_d = pulse_val;
            2'd2:    s1_wave_d = tri_val;
            default: s1_wave_d = saw_val;
        endcase

        s1_valid_d = enable_i;
    end

    // S2: registered ROM read; the S1 results are delayed to stay aligned
    // with the ROM data.
    always_comb begin
        s2_rom_d   = rom[s1_addr_q];
        s2_neg_d   = s1_neg_q;
        s2_sine_d  = s1_sine_q;
        s2_wave_d  = s1_wave_q;
        s2_valid_d = s1_valid_q;
    end

    // S3: apply the quadrant sign to the table value, then select the
    // result. Between samples the output holds its last value.
    always_comb begin
        sine_val = s2_neg_q ? (OUT_BITS'(0) - {1'b0, s2_rom_q}) : {1'b0, s2_rom_q};
        sample_d = sample_q;
        if (s2_valid_q) begin
            sample_d = s2_sine_q ? sine_val : s2_wave_q;
        end
        valid_d = s2_valid_q;
    end

    // The valid chain and the output sample are reset. Reset discards
    // in-flight samples and ignores enables that arrive during reset.
    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            valid_q    <= 1'b0;
            sample_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            valid_q    <= valid_d;
            sample_q   <= sample_d;
        end
    end

    // The data path advances every cycle with no reset, so the ROM read
    // register can map onto block RAM or LUT ROM.
    always_ff @(posedge clk_i) begin
        s1_addr_q <= s1_addr_d;
        s1_neg_q  <= s1_neg_d;
        s1_sine_q <= s1_sine_d;
        s1_wave_q <= s1_wave_d;
        s2_rom_q  <= s2_rom_d;
        s2_neg_q  <= s2_neg_d;
        s2_sine_q <= s2_sine_d;
        s2_wave_q <= s2_wave_d;
    end

    // The outputs are masked for the whole cycle in which reset is held.
    // Without this, a sample from an enable issued three cycles before reset
    // would still appear in the reset cycle itself, even though reset is
    // meant to discard it.
    assign valid_o  = valid_q & n_rst_i;
    assign sample_o = n_rst_i ? sample_q : '0;

endmodule

// File: tb/tb_waveform_shaper.sv
// Testbench for waveform_shaper.
// Inputs change 1 ns after each rising edge and outputs are checked on the
// falling edge. A queue-based reference model computes each sample from the
// waveform definitions. It marks each sample due two edges after the edge
// that captured its enable.

module tb_waveform_shaper;

    logic        clk = 1'b0;
    logic        n_rst_i;
    logic        enable_i;
    logic [31:0] phase_i;
    logic [1:0]  wave_sel_i;
    logic [31:0] pulse_width_i;
    logic [15:0] sample_o;
    logic        valid_o;

    waveform_shaper #(
        .WORD_BITS(32),
        .OUT_BITS (16),
        .LUT_BITS (10)
    ) dut (
        .clk_i        (clk),
        .n_rst_i      (n_rst_i),
        .enable_i     (enable_i),
        .phase_i      (phase_i),
        .wave_sel_i   (wave_sel_i),
        .pulse_width_i(pulse_width_i),
        .sample_o     (sample_o),
        .valid_o      (valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] value;
    } pend_t;

    pend_t       pend[$];
    int          cyc         = 0;
    int          vectors     = 0;
    int          miscompares = 0;
    logic        prev_en     = 1'b0;
    logic        prev_rst    = 1'b0;
    logic [31:0] prev_ph     = '0;
    logic [31:0] prev_pw     = '0;
    logic [1:0]  prev_sel    = '0;
    logic        cur_valid   = 1'b0;
    logic [15:0] last_sample = '0;
    logic        exp_valid;
    logic [15:0] exp_sample;
    logic [15:0] sweep [4096];

    // Reference waveform computed from its mathematical definition
    function automatic int model_sample(input logic [31:0] ph, input logic [1:0] sel,
                                        input logic [31:0] pw);
        int  q;
        int  u;
        int  quad;
        int  idx;
        int  k;
        int  mag;
        real r;
        case (sel)
            2'd0: model_sample = int'(ph >> 16) - 32768;
            2'd1: model_sample = (ph < pw) ? 32767 : -32767;
            2'd2: begin
                q = int'(ph >> 15);
                u = (q < 65536) ? q : 131071 - q;
                model_sample = u - 32768;
            end
            default: begin
                quad = int'(ph >> 30);
                idx  = int'((ph >> 20) & 32'h3FF);
                k    = (quad % 2 == 1) ? 1023 - idx : idx;
                r    = $sin(3.14159265358979 / 2.0 * (real'(k) + 0.5) / 1024.0);
                mag  = $rtoi(32767.0 * r + 0.5);
                model_sample = (quad >= 2) ? -mag : mag;
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_pw();
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Advance one clock. The model sees the inputs that were on the pins at
    // the edge. New inputs are then driven, and the expected outputs for the
    // falling edge are computed.
    task automatic step(input logic rst_n, input logic en, input logic [1:0] sel,
                        input logic [31:0] ph, input logic [31:0] pw);
        @(posedge clk);
        cyc++;
        if (!prev_rst) begin
            pend.delete();
            cur_valid   = 1'b0;
            last_sample = '0;
        end else begin
            if (prev_en)
                pend.push_back('{cyc + 2, 16'(model_sample(prev_ph, prev_sel, prev_pw))});
            cur_valid = 1'b0;
            if (pend.size() != 0 && pend[0].due == cyc) begin
                cur_valid   = 1'b1;
                last_sample = pend[0].value;
                void'(pend.pop_front());
            end
        end
        #1;
        n_rst_i       = rst_n;
        enable_i      = en;
        wave_sel_i    = sel;
        phase_i       = ph;
        pulse_width_i = pw;
        prev_rst      = rst_n;
        prev_en       = en;
        prev_sel      = sel;
        prev_ph       = ph;
        prev_pw       = pw;
        @(negedge clk);
        exp_valid  = rst_n ? cur_valid : 1'b0;
        exp_sample = rst_n ? last_sample : 16'h0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 7; i++) begin
            step(i >= 4, (i < 4) ? i[0] : 1'b0, 2'($urandom), $urandom, $urandom);
            vectors++;
            if (valid_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_valid step=%0d got %b want 0", i, valid_o);
            end
            vectors++;
            if (sample_o !== 16'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_sample step=%0d got %h want 0000", i, sample_o);
            end
        end
    endtask

    task automatic test_points();
        logic [31:0] ph_t [14] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF,
                                   32'h0, 32'h4000_0000, 32'h8000_0000,
                                   32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF,
                                   32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
        logic [1:0]  sel_t [14] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2,
                                   2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3};
        logic [31:0] pw_t  [14] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                   32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0,
                                   32'h0, 32'h0, 32'h0, 32'h0};
        int          want  [14] = '{-32768, 0, 32767, -32768, 0, 32767,
                                   32767, -32767, -32767, -32767, 25, 32767, -25, -32767};
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b1, sel_t[i], ph_t[i], pw_t[i]);
            for (int j = 0; j < 3; j++) begin
                step(1'b1, 1'b0, 2'($urandom), $urandom, $urandom);
                vectors++;
                if (valid_o !== (j == 2)) begin
                    miscompares++;
                    $display("[TB] FAIL point_valid %0d lag=%0d got %b want %b", i, j + 1, valid_o, j == 2);
                end
            end
            vectors++;
            if (sample_o !== 16'(want[i])) begin
                miscompares++;
                $display("[TB] FAIL point %0d sel=%0d phase=%h got %0d want %0d",
                         i, sel_t[i], ph_t[i], $signed(sample_o), want[i]);
            end
        end
    endtask

    task automatic test_sine_sweep();
        int          n = 0;
        int          want;
        logic [31:0] ph;
        for (int i = 0; i < 4099; i++) begin
            step(1'b1, i < 4096, 2'd3, 32'(i) << 20, $urandom);
            vectors++;
            if (valid_o !== exp_valid || sample_o !== exp_sample) begin
                miscompares++;
                $display("[TB] FAIL sweep step=%0d got %b/%0d want %b/%0d",
                         i, valid_o, $signed(sample_o), exp_valid, $signed(exp_sample));
            end
            if (valid_o === 1'b1 && n < 4096) begin
                sweep[n] = sample_o;
                n++;
            end
        end
        vectors++;
        if (n !== 4096) begin
            miscompares++;
            $display("[TB] FAIL sweep_count got %0d want 4096", n);
        end
        for (int i = 0; i < 4096; i++) begin
            vectors++;
            if ($signed(sweep[i]) < -32767) begin
                miscompares++;
                $display("[TB] FAIL sweep_bound %0d got %0d", i, $signed(sweep[i]));
            end
            // The sample at the phase mirrored through half a period must be
            // the negated sample.
            ph   = ~(32'(i) << 20);
            want = -model_sample(ph, 2'd3, 32'h0);
            vectors++;
            if (sweep[i] !== 16'(want)) begin
                miscompares++;
                $display("[TB] FAIL sweep_symmetry %0d got %0d want %0d", i, $signed(sweep[i]), want);
            end
        end
    endtask

    task automatic test_pipeline();
        int count = 0;
        int first = -1;
        int last  = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, i < 8, 2'(i % 4), $urandom, rand_pw());
            vectors++;
            if (valid_o !== exp_valid || sample_o !== exp_sample) begin
                miscompares++;
                $display("[TB] FAIL pipeline step=%0d got %b/%0d want %b/%0d",
                         i, valid_o, $signed(sample_o), exp_valid, $signed(exp_sample));
            end
            if (valid_o === 1'b1) begin
                count++;
                if (first < 0) first = i;
                last = i;
            end
        end
        vectors++;
        if (count !== 8 || first !== 3 || last !== 10) begin
            miscompares++;
            $display("[TB] FAIL pipeline_window got count=%0d first=%0d last=%0d want 8/3/10",
                     count, first, last);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 7, 2'($urandom),
                 $urandom, rand_pw());
            vectors++;
            if (valid_o !== exp_valid) begin
                miscompares++;
                $display("[TB] FAIL random_valid step=%0d got %b want %b", i, valid_o, exp_valid);
            end
            vectors++;
            if (sample_o !== exp_sample) begin
                miscompares++;
                $display("[TB] FAIL random_sample step=%0d got %0d want %0d",
                         i, $signed(sample_o), $signed(exp_sample));
            end
        end
    endtask

    task automatic test_midstream_reset();
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 2'd0, '0, '0);
        // Burst of three, reset on the cycle after, then a quiet period
        for (int i = 0; i < 8; i++) begin
            step(i != 3, i <= 3, 2'(i), $urandom, 32'hFFFF_FFFF);
            vectors++;
            if (valid_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL midreset_valid step=%0d got %b want 0", i, valid_o);
            end
            vectors++;
            if (sample_o !== exp_sample) begin
                miscompares++;
                $display("[TB] FAIL midreset_sample step=%0d got %0d want %0d",
                         i, $signed(sample_o), $signed(exp_sample));
            end
            if (i >= 3) begin
                vectors++;
                if (sample_o !== 16'h0) begin
                    miscompares++;
                    $display("[TB] FAIL midreset_zero step=%0d got %0d want 0", i, $signed(sample_o));
                end
            end
        end
        step(1'b1, 1'b1, 2'd3, 32'h4000_0000, '0);
        for (int j = 0; j < 3; j++) begin
            step(1'b1, 1'b0, 2'd0, '0, '0);
            vectors++;
            if (valid_o !== (j == 2) || sample_o !== ((j == 2) ? 16'h7FFF : 16'h0)) begin
                miscompares++;
                $display("[TB] FAIL midreset_recover lag=%0d got %b/%0d want %b/%0d",
                         j + 1, valid_o, $signed(sample_o), j == 2, (j == 2) ? 32767 : 0);
            end
        end
    endtask

    initial begin
        n_rst_i       = 1'b0;
        enable_i      = 1'b0;
        phase_i       = '0;
        wave_sel_i    = '0;
        pulse_width_i = '0;
        $display("[TB] waveform_shaper bench start");
        test_reset();
        test_points();
        test_pipeline();
        test_sine_sweep();
        test_back_to_back();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
